mc_controller: RTL and testbench

//  Control unit for the multicycle RV32I core variant.
//  - Sequences one shared ALU, one unified instruction/data memory and the register file over 3-5 cycles per instr.
//  - Main FSM: state-driven mux selects/enables; the ALU control field is derived from ALUOp/funct3/funct7b5.
//  - Also holds memory-wait handshake, sticky illegal-instruction halt, and retired-instruction counter.

---
 rtl/mc_pkg.sv | 93 +++++++++
 rtl/mc_if.sv | 34 +++
 rtl/mc_main_fsm.sv | 110 +++++++++++
 rtl/mc_controller.sv | 90 +++++++++
 tb/tb_mc_controller.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mc_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned ALUC_W = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_HALT
    } state_e;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b101;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // State-driven control word produced by the main FSM
    typedef struct packed {
        logic             pc_update;
        logic             branch;
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic [SEL_W-1:0] res_src;
        logic [SEL_W-1:0] src_a;
        logic [SEL_W-1:0] src_b;
        alu_op_e          alu_op;
    } ctrl_t;

    // Successor of DECODE; anything unsupported lands in HALT
    function automatic state_e decode_next(input logic [OP_W-1:0] op,
                                           input logic [F3_W-1:0] funct3,
                                           input logic            funct7b5);
        state_e nxt;
        logic   f3_ok;
        f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:   nxt = (f3_ok && (!funct7b5 || funct3 == 3'b000)) ? S_EXECR : S_HALT;
            OP_I:   nxt = f3_ok ? S_EXECI : S_HALT;
            OP_JAL: nxt = S_JAL;
            OP_BEQ: nxt = (funct3 == 3'b000) ? S_BEQ : S_HALT;
            default: nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface mc_if #(
    parameter int unsigned ICOUNT_W = 32
) ();
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic                funct7b5;
    logic                Zero;
    logic                mem_ready;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic                RegWrite;
    logic [1:0]          ImmSrc;
    logic [2:0]          ALUControl;
    logic                illegal;
    logic [ICOUNT_W-1:0] instret;

    modport master (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal, instret
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal, instret
    );
endinterface

// File: rtl/mc_main_fsm.sv
// Main sequencing FSM: state register, next-state logic and Moore control decode.
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter bit STALL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [F3_W-1:0] funct3,
    input  logic            funct7b5,
    input  logic            mem_ready,
    output ctrl_t           ctrl_c,
    output logic            retire_c,
    output logic            halt_c
);

    state_e state_q, state_d;
    logic   ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        ready_c        = mem_ready | ~STALL_EN;
        state_d        = state_q;
        ctrl_c         = '0;
        ctrl_c.alu_op  = ALUOP_ADD;
        retire_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.src_a     = SRCA_PC;
                ctrl_c.src_b     = SRCB_FOUR;
                ctrl_c.res_src   = RES_ALURESULT;
                ctrl_c.ir_write  = ready_c;
                ctrl_c.pc_update = ready_c;
                if (ready_c) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl_c.src_a = SRCA_OLDPC;
                ctrl_c.src_b = SRCB_IMM;
                state_d      = decode_next(op, funct3, funct7b5);
            end
            S_MEMADR: begin
                ctrl_c.src_a = SRCA_RS1;
                ctrl_c.src_b = SRCB_IMM;
                state_d      = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl_c.adr_src = 1'b1;
                if (ready_c) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_c.res_src   = RES_DATA;
                ctrl_c.reg_write = 1'b1;
                state_d          = S_FETCH;
                retire_c         = 1'b1;
            end
            // Strobe stays up through every wait cycle until memory accepts
            S_MEMWRITE: begin
                ctrl_c.adr_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                if (ready_c) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_EXECR: begin
                ctrl_c.src_a  = SRCA_RS1;
                ctrl_c.src_b  = SRCB_RS2;
                ctrl_c.alu_op = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                ctrl_c.src_a  = SRCA_RS1;
                ctrl_c.src_b  = SRCB_IMM;
                ctrl_c.alu_op = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.res_src   = RES_ALUOUT;
                ctrl_c.reg_write = 1'b1;
                state_d          = S_FETCH;
                retire_c         = 1'b1;
            end
            S_JAL: begin
                ctrl_c.src_a     = SRCA_OLDPC;
                ctrl_c.src_b     = SRCB_FOUR;
                ctrl_c.res_src   = RES_ALUOUT;
                ctrl_c.pc_update = 1'b1;
                state_d          = S_ALUWB;
            end
            S_BEQ: begin
                ctrl_c.src_a   = SRCA_RS1;
                ctrl_c.src_b   = SRCB_RS2;
                ctrl_c.alu_op  = ALUOP_SUB;
                ctrl_c.res_src = RES_ALUOUT;
                ctrl_c.branch  = 1'b1;
                state_d        = S_FETCH;
                retire_c       = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        halt_c = (state_d == S_HALT);
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: main FSM plus ALU/immediate decode, PC enable and status.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit          STALL_EN = 1'b1,
    parameter int unsigned ICOUNT_W = 32
) (
    input  logic clk,
    input  logic reset,
    mc_if.slave  bus
);

    ctrl_t               ctrl_c;
    logic                retire_c;
    logic                halt_c;
    logic [ALUC_W-1:0]   alu_ctrl_c;
    logic [SEL_W-1:0]    imm_src_c;
    logic                illegal_q, illegal_d;
    logic [ICOUNT_W-1:0] instret_q, instret_d;

    mc_main_fsm #(.STALL_EN(STALL_EN)) u_main_fsm (
        .clk       (clk),
        .reset     (reset),
        .op        (bus.op),
        .funct3    (bus.funct3),
        .funct7b5  (bus.funct7b5),
        .mem_ready (bus.mem_ready),
        .ctrl_c    (ctrl_c),
        .retire_c  (retire_c),
        .halt_c    (halt_c)
    );

    // Subtract only for R-type funct7b5; for I-type that bit belongs to the immediate
    always_comb begin
        alu_ctrl_c = ALUC_ADD;
        case (ctrl_c.alu_op)
            ALUOP_SUB: alu_ctrl_c = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct3)
                    3'b000:  alu_ctrl_c = (bus.funct7b5 & bus.op[5]) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_ctrl_c = ALUC_SLT;
                    3'b110:  alu_ctrl_c = ALUC_OR;
                    3'b111:  alu_ctrl_c = ALUC_AND;
                    default: alu_ctrl_c = ALUC_ADD;
                endcase
            end
            default: alu_ctrl_c = ALUC_ADD;
        endcase
    end

    always_comb begin
        imm_src_c = IMM_I;
        case (bus.op)
            OP_LW, OP_I: imm_src_c = IMM_I;
            OP_SW:       imm_src_c = IMM_S;
            OP_BEQ:      imm_src_c = IMM_B;
            OP_JAL:      imm_src_c = IMM_J;
            default:     imm_src_c = IMM_I;
        endcase
    end

    always_comb begin
        illegal_d = illegal_q | halt_c;
        instret_d = instret_q + ICOUNT_W'(retire_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign bus.PCWrite    = ctrl_c.pc_update | (ctrl_c.branch & bus.Zero);
    assign bus.AdrSrc     = ctrl_c.adr_src;
    assign bus.MemWrite   = ctrl_c.mem_write;
    assign bus.IRWrite    = ctrl_c.ir_write;
    assign bus.ResultSrc  = ctrl_c.res_src;
    assign bus.ALUSrcA    = ctrl_c.src_a;
    assign bus.ALUSrcB    = ctrl_c.src_b;
    assign bus.RegWrite   = ctrl_c.reg_write;
    assign bus.ImmSrc     = imm_src_c;
    assign bus.ALUControl = alu_ctrl_c;
    assign bus.illegal    = illegal_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; a 4-bit-instret copy shadows the same stimulus for wrap checks.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mc_if #(.ICOUNT_W(32)) if0 ();
    mc_if #(.ICOUNT_W(4))  if1 ();

    assign if1.op        = if0.op;
    assign if1.funct3    = if0.funct3;
    assign if1.funct7b5  = if0.funct7b5;
    assign if1.Zero      = if0.Zero;
    assign if1.mem_ready = if0.mem_ready;

    mc_controller #(.STALL_EN(1'b1), .ICOUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    mc_controller #(.STALL_EN(1'b1), .ICOUNT_W(4)) dut_w4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_LUI = 7'b0110111;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite}
    localparam logic [10:0] C_FETCH    = 11'b1_0_0_1_10_00_10_0;
    localparam logic [10:0] C_FETCH_W  = 11'b0_0_0_0_10_00_10_0;
    localparam logic [10:0] C_DECODE   = 11'b0_0_0_0_00_01_01_0;
    localparam logic [10:0] C_MEMADR   = 11'b0_0_0_0_00_10_01_0;
    localparam logic [10:0] C_MEMREAD  = 11'b0_1_0_0_00_00_00_0;
    localparam logic [10:0] C_MEMWB    = 11'b0_0_0_0_01_00_00_1;
    localparam logic [10:0] C_MEMWRITE = 11'b0_1_1_0_00_00_00_0;
    localparam logic [10:0] C_EXECR    = 11'b0_0_0_0_00_10_00_0;
    localparam logic [10:0] C_EXECI    = 11'b0_0_0_0_00_10_01_0;
    localparam logic [10:0] C_ALUWB    = 11'b0_0_0_0_00_00_00_1;
    localparam logic [10:0] C_JAL      = 11'b1_0_0_0_00_01_10_0;
    localparam logic [10:0] C_BEQ_T    = 11'b1_0_0_0_00_10_00_0;
    localparam logic [10:0] C_BEQ_NT   = 11'b0_0_0_0_00_10_00_0;
    localparam logic [10:0] C_HALT     = 11'b0_0_0_0_00_00_00_0;

    logic [10:0] ctl_obs;
    assign ctl_obs = {if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.ResultSrc,
                      if0.ALUSrcA, if0.ALUSrcB, if0.RegWrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [10:0] exp);
        check(tag, 32'(ctl_obs), 32'(exp));
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if0.op       = o;
        if0.funct3   = f3;
        if0.funct7b5 = f7;
    endtask

    logic [2:0] r_f3   [3] = '{3'b010, 3'b110, 3'b111};
    logic [2:0] r_aluc [3] = '{3'b101, 3'b011, 3'b010};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        if0.Zero      = 1'b0;
        if0.mem_ready = 1'b1;
        set_instr(T_LW, 3'b010, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk_ctl("rst_fetch", C_FETCH);
        check("rst_illegal", 32'(if0.illegal), 32'd0);
        check("rst_instret", if0.instret, 32'd0);
        check("lw_imm", 32'(if0.ImmSrc), 32'd0);
        check("fetch_aluc", 32'(if0.ALUControl), 32'd0);
        reset = 1'b0;

        // lw: 5 cycles
        cyc(); chk_ctl("lw_decode", C_DECODE);
        cyc(); chk_ctl("lw_memadr", C_MEMADR);
        cyc(); chk_ctl("lw_memread", C_MEMREAD);
        cyc(); chk_ctl("lw_memwb", C_MEMWB);
        cyc(); chk_ctl("lw_fetch", C_FETCH);
        check("lw_instret", if0.instret, 32'd1);

        // sw with three wait cycles in MEMWRITE
        set_instr(T_SW, 3'b010, 1'b0); #1;
        check("sw_imm", 32'(if0.ImmSrc), 32'd1);
        cyc();
        cyc(); chk_ctl("sw_memadr", C_MEMADR);
        cyc(); if0.mem_ready = 1'b0; #1;
        chk_ctl("sw_wait0", C_MEMWRITE);
        for (int i = 1; i < 3; i++) begin
            cyc(); chk_ctl("sw_wait", C_MEMWRITE);
        end
        cyc(); if0.mem_ready = 1'b1; #1;
        chk_ctl("sw_accept", C_MEMWRITE);
        cyc(); chk_ctl("sw_fetch", C_FETCH);
        check("sw_instret", if0.instret, 32'd2);

        // sub, with one fetch stall
        set_instr(T_R, 3'b000, 1'b1); if0.mem_ready = 1'b0; #1;
        chk_ctl("fetch_stall", C_FETCH_W);
        cyc(); if0.mem_ready = 1'b1; #1;
        chk_ctl("fetch_held", C_FETCH);
        cyc(); chk_ctl("sub_decode", C_DECODE);
        cyc(); chk_ctl("sub_execr", C_EXECR);
        check("sub_aluc", 32'(if0.ALUControl), 32'd1);
        cyc(); chk_ctl("sub_aluwb", C_ALUWB);
        cyc(); check("sub_instret", if0.instret, 32'd3);

        // addi with funct7b5 set stays an add
        set_instr(T_I, 3'b000, 1'b1);
        cyc(); cyc(); chk_ctl("addi_execi", C_EXECI);
        check("addi_aluc", 32'(if0.ALUControl), 32'd0);
        cyc(); cyc(); check("addi_instret", if0.instret, 32'd4);

        // slt / or / and
        for (int i = 0; i < 3; i++) begin
            set_instr(T_R, r_f3[i], 1'b0);
            cyc(); cyc();
            check("r_aluc", 32'(if0.ALUControl), 32'(r_aluc[i]));
            cyc(); cyc();
        end
        check("r_instret", if0.instret, 32'd7);

        // beq taken / not taken
        set_instr(T_BEQ, 3'b000, 1'b0); #1;
        check("beq_imm", 32'(if0.ImmSrc), 32'd2);
        cyc(); cyc(); if0.Zero = 1'b1; #1;
        chk_ctl("beq_taken", C_BEQ_T);
        check("beq_aluc", 32'(if0.ALUControl), 32'd1);
        cyc(); chk_ctl("beq_fetch", C_FETCH);
        check("beq_instret", if0.instret, 32'd8);
        if0.Zero = 1'b0;
        cyc(); cyc(); chk_ctl("beq_not_taken", C_BEQ_NT);
        cyc(); check("beqn_instret", if0.instret, 32'd9);

        // jal
        set_instr(T_JAL, 3'b000, 1'b0); #1;
        check("jal_imm", 32'(if0.ImmSrc), 32'd3);
        cyc(); cyc(); chk_ctl("jal_jal", C_JAL);
        cyc(); chk_ctl("jal_aluwb", C_ALUWB);
        cyc(); check("jal_instret", if0.instret, 32'd10);

        // lui is unsupported: halt until reset
        set_instr(T_LUI, 3'b000, 1'b0);
        cyc(); chk_ctl("lui_decode", C_DECODE);
        cyc(); chk_ctl("lui_halt", C_HALT);
        check("lui_illegal", 32'(if0.illegal), 32'd1);
        cyc(); cyc(); chk_ctl("halt_stays", C_HALT);
        check("halt_instret", if0.instret, 32'd10);
        reset = 1'b1; #1;
        chk_ctl("halt_reset_fetch", C_FETCH);
        check("halt_reset_illegal", 32'(if0.illegal), 32'd0);
        check("halt_reset_instret", if0.instret, 32'd0);
        check("halt_reset_w4", 32'(if1.instret), 32'd0);
        #1; reset = 1'b0;

        // R-type funct7b5 only legal with funct3=000
        set_instr(T_R, 3'b010, 1'b1);
        cyc(); cyc();
        check("slt_f7_illegal", 32'(if0.illegal), 32'd1);
        reset = 1'b1; #1; reset = 1'b0; #1;
        check("slt_f7_cleared", 32'(if0.illegal), 32'd0);

        // reset mid-MEMWRITE drops the strobe without a clock edge
        set_instr(T_SW, 3'b010, 1'b0);
        cyc(); cyc(); cyc(); if0.mem_ready = 1'b0; #1;
        check("sw2_memwrite", 32'(if0.MemWrite), 32'd1);
        reset = 1'b1; #1;
        check("sw2_rst_memwrite", 32'(if0.MemWrite), 32'd0);
        chk_ctl("sw2_rst_fetch", C_FETCH_W);
        reset = 1'b0; if0.mem_ready = 1'b1;

        // 16 beqs: 4-bit counter wraps 15 -> 0
        set_instr(T_BEQ, 3'b000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(); cyc(); cyc();
            if (i == 14) check("w4_instret_15", 32'(if1.instret), 32'd15);
        end
        check("w4_instret_wrap", 32'(if1.instret), 32'd0);
        check("w32_instret_16", if0.instret, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
